urv_dm_arbiter: RTL

Shares the single uRV data-memory port between the core execute stage (core port) and a host/debug master (host port). It sits between the exec stage's load/store address, data and select outputs and the memory bus. Each port gets one transaction at a time, granted by fixed core priority with a host anti-starvation override. Memory accesses are sequenced by a three-state machine with a bus timeout.

---
 rtl/urv_dm_arbiter_pkg.sv | 19 +
 rtl/urv_dm_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/urv_dm_arbiter_pkg.sv
// urv_dm_arbiter_pkg: state encodings, request bundle and counter helper for the data-memory arbiter
package urv_dm_arbiter_pkg;

    localparam logic [1:0] DMA_IDLE = 2'd0;
    localparam logic [1:0] DMA_CORE = 2'd1;
    localparam logic [1:0] DMA_HOST = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } dm_req_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v + {7'd0, v != 8'hff};
    endfunction

endpackage

// File: rtl/urv_dm_arbiter.sv
// urv_dm_arbiter: shares the uRV data-memory port between the core and a host master
module urv_dm_arbiter
    import urv_dm_arbiter_pkg::*;
#(
    parameter int HOST_MAX_WAIT  = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        c_req_i,
    input  logic        c_we_i,
    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_data_i,
    input  logic [3:0]  c_sel_i,
    output logic        c_ack_o,
    output logic        c_err_o,
    output logic [31:0] c_data_o,
    input  logic        h_req_i,
    input  logic        h_we_i,
    input  logic [31:0] h_addr_i,
    input  logic [31:0] h_data_i,
    input  logic [3:0]  h_sel_i,
    output logic        h_ack_o,
    output logic        h_err_o,
    output logic [31:0] h_data_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_s_o,
    output logic [3:0]  m_data_select_o,
    output logic        m_load_o,
    output logic        m_store_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_data_l_i,
    output logic        busy_o
);

    localparam logic [7:0] HOST_LIMIT = 8'(HOST_MAX_WAIT);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam bit         TO_EN      = TIMEOUT_CYCLES != 0;

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_q, wait_d, host_wait_q, host_wait_d;
    logic [31:0] m_addr_q, m_addr_d, m_data_s_q, m_data_s_d;
    logic [3:0]  m_sel_q, m_sel_d;
    logic        m_load_q, m_load_d, m_store_q, m_store_d;
    logic        c_ack_q, c_ack_d, c_err_q, c_err_d, h_ack_q, h_ack_d, h_err_q, h_err_d;
    logic [31:0] c_data_q, c_data_d, h_data_q, h_data_d;
    logic        busy_q, busy_d;
    logic        c_elig, h_elig, host_grant, core_grant, finish;
    logic [31:0] done_data;
    dm_req_t     c_in, h_in, win;

    assign c_in = {c_we_i, c_addr_i, c_data_i, c_sel_i};
    assign h_in = {h_we_i, h_addr_i, h_data_i, h_sel_i};

    // a port still seeing its ack this cycle is finishing, not asking again
    assign c_elig     = c_req_i && !c_ack_q;
    assign h_elig     = h_req_i && !h_ack_q;
    assign host_grant = state_q == DMA_IDLE && h_elig && (host_wait_q >= HOST_LIMIT || !c_elig);
    assign core_grant = state_q == DMA_IDLE && c_elig && !host_grant;
    assign win        = host_grant ? h_in : c_in;
    assign finish     = state_q != DMA_IDLE && (m_ready_i || (TO_EN && wait_q == TO_LAST));
    assign done_data  = m_ready_i && m_load_q ? m_data_l_i : 32'd0;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        m_addr_d    = m_addr_q;
        m_data_s_d  = m_data_s_q;
        m_sel_d     = m_sel_q;
        m_load_d    = m_load_q;
        m_store_d   = m_store_q;
        c_ack_d     = 1'b0;
        c_err_d     = 1'b0;
        h_ack_d     = 1'b0;
        h_err_d     = 1'b0;
        c_data_d    = c_data_q;
        h_data_d    = h_data_q;
        if (host_grant || core_grant) begin
            m_addr_d   = win.addr;
            m_data_s_d = win.data;
            m_sel_d    = win.sel;
            m_store_d  = win.we;
            m_load_d   = !win.we;
            wait_d     = 8'd0;
            state_d    = host_grant ? DMA_HOST : DMA_CORE;
        end else if (finish) begin
            m_load_d  = 1'b0;
            m_store_d = 1'b0;
            state_d   = DMA_IDLE;
            c_ack_d   = state_q == DMA_CORE;
            h_ack_d   = state_q == DMA_HOST;
            c_err_d   = state_q == DMA_CORE && !m_ready_i;
            h_err_d   = state_q == DMA_HOST && !m_ready_i;
            c_data_d  = state_q == DMA_CORE ? done_data : c_data_q;
            h_data_d  = state_q == DMA_HOST ? done_data : h_data_q;
        end else if (state_q != DMA_IDLE) begin
            wait_d = sat_inc(wait_q);
        end
        host_wait_d = (!h_req_i || host_grant) ? 8'd0 : sat_inc(host_wait_q);
        busy_d      = state_d != DMA_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= DMA_IDLE;
            wait_q      <= 8'd0;
            host_wait_q <= 8'd0;
            m_addr_q    <= 32'd0;
            m_data_s_q  <= 32'd0;
            m_sel_q     <= 4'd0;
            m_load_q    <= 1'b0;
            m_store_q   <= 1'b0;
            c_ack_q     <= 1'b0;
            c_err_q     <= 1'b0;
            h_ack_q     <= 1'b0;
            h_err_q     <= 1'b0;
            c_data_q    <= 32'd0;
            h_data_q    <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            host_wait_q <= host_wait_d;
            m_addr_q    <= m_addr_d;
            m_data_s_q  <= m_data_s_d;
            m_sel_q     <= m_sel_d;
            m_load_q    <= m_load_d;
            m_store_q   <= m_store_d;
            c_ack_q     <= c_ack_d;
            c_err_q     <= c_err_d;
            h_ack_q     <= h_ack_d;
            h_err_q     <= h_err_d;
            c_data_q    <= c_data_d;
            h_data_q    <= h_data_d;
            busy_q      <= busy_d;
        end
    end

    assign c_ack_o         = c_ack_q;
    assign c_err_o         = c_err_q;
    assign c_data_o        = c_data_q;
    assign h_ack_o         = h_ack_q;
    assign h_err_o         = h_err_q;
    assign h_data_o        = h_data_q;
    assign m_addr_o        = m_addr_q;
    assign m_data_s_o      = m_data_s_q;
    assign m_data_select_o = m_sel_q;
    assign m_load_o        = m_load_q;
    assign m_store_o       = m_store_q;
    assign busy_o          = busy_q;

endmodule
